// File: rtl/song_reader.sv
// Song reader: walks the selected song's {note, duration} table in a synchronous
// ROM and hands each entry to the note player through a new_note/note_done handshake.
module song_reader #(
    parameter int SONG_BITS  = 2,
    parameter int INDEX_BITS = 5,
    parameter int NOTE_BITS  = 6,
    parameter int DUR_BITS   = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic                            reset_play,
    input  logic [SONG_BITS-1:0]            song,
    input  logic                            note_done,
    output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
    input  logic [NOTE_BITS+DUR_BITS-1:0]   rom_data,
    output logic [NOTE_BITS-1:0]            note,
    output logic [DUR_BITS-1:0]             duration,
    output logic                            new_note,
    output logic                            song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_NOTE,
        ADVANCE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [INDEX_BITS-1:0] index;
    logic [INDEX_BITS-1:0] index_next;
    logic [NOTE_BITS-1:0]  note_next;
    logic [DUR_BITS-1:0]   duration_next;
    logic                  new_note_next;
    logic                  song_done_next;
    logic [NOTE_BITS-1:0]  rom_note;
    logic [DUR_BITS-1:0]   rom_dur;

    assign rom_addr = {song, index};
    assign rom_note = rom_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
    assign rom_dur  = rom_data[DUR_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_next;
            index     <= index_next;
            note      <= note_next;
            duration  <= duration_next;
            new_note  <= new_note_next;
            song_done <= song_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        index_next     = index;
        note_next      = note;
        duration_next  = duration;
        new_note_next  = 1'b0;
        song_done_next = 1'b0;

        if (reset_play) begin
            state_next = IDLE;
            index_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (play) state_next = FETCH;
                end
                FETCH: begin
                    if (play) state_next = LATCH;
                end
                LATCH: begin
                    // A zero-duration entry terminates the song without replacing the held note.
                    if (rom_dur == '0) begin
                        state_next = DONE;
                    end else begin
                        note_next     = rom_note;
                        duration_next = rom_dur;
                        if (play) state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (play) begin
                        new_note_next = 1'b1;
                        state_next    = WAIT_NOTE;
                    end
                end
                WAIT_NOTE: begin
                    // new_note is registered, so its pulse lands in the first WAIT_NOTE cycle;
                    // a note_done coincident with it belongs to no started note and is dropped.
                    if (note_done && !new_note) state_next = ADVANCE;
                end
                ADVANCE: begin
                    if (index == '1) begin
                        state_next = DONE;
                    end else begin
                        index_next = index + 1'b1;
                        state_next = FETCH;
                    end
                end
                DONE: begin
                    index_next = '0;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
            song_done_next = (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: ROM model plus a queue of expected {note, duration, address}
// entries pushed as songs are loaded and popped on every new_note pulse.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        reset_play;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        song_done;

    typedef struct packed {
        logic [5:0] n;
        logic [5:0] d;
        logic [6:0] a;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] rom [0:127];
    int          total = 0;
    int          bad = 0;
    int          pulse_err = 0;
    logic        prev_nn = 1'b0;
    logic        prev_sd = 1'b0;

    song_reader #(
        .SONG_BITS (2),
        .INDEX_BITS(5),
        .NOTE_BITS (6),
        .DUR_BITS  (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .reset_play(reset_play),
        .song      (song),
        .note_done (note_done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // Neither pulse output may stay high for two consecutive cycles.
    always @(negedge clk) begin
        if ((new_note && prev_nn) || (song_done && prev_sd)) pulse_err <= pulse_err + 1;
        prev_nn <= new_note;
        prev_sd <= song_done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [6:0] a);
        exp_t e;
        logic [11:0] w;
        w   = rom[a];
        e.n = w[11:6];
        e.d = w[5:0];
        e.a = a;
        exp_q.push_back(e);
    endtask

    task automatic restart();
        play       = 1'b0;
        note_done  = 1'b0;
        reset_play = 1'b1;
        tick();
        reset_play = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        play       = 1'b0;
        reset_play = 1'b0;
        note_done  = 1'b0;
        song       = 2'd1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (note !== 6'd0) begin bad++; $display("FAIL reset_note got=%0d want=0", note); end
        total++; if (duration !== 6'd0) begin bad++; $display("FAIL reset_duration got=%0d want=0", duration); end
        total++; if (new_note !== 1'b0) begin bad++; $display("FAIL reset_new_note got=%b want=0", new_note); end
        total++; if (song_done !== 1'b0) begin bad++; $display("FAIL reset_song_done got=%b want=0", song_done); end
        total++; if (rom_addr !== 7'h20) begin bad++; $display("FAIL reset_rom_addr got=%h want=20", rom_addr); end
    endtask

    task automatic test_basic_song();
        exp_t e;
        int nn, nd_cnt, nd_tick, want_c, done;
        rom[7'h20] = {6'd5, 6'd3};
        rom[7'h21] = {6'd9, 6'd2};
        rom[7'h22] = {6'd12, 6'd4};
        rom[7'h23] = {6'd33, 6'd0};
        exp_q.delete();
        push_exp(7'h20); push_exp(7'h21); push_exp(7'h22);
        song = 2'd1;
        play = 1'b1;
        nn = 0; nd_cnt = 0; nd_tick = -100; done = 0;
        for (int c = 1; c <= 150 && done == 0; c++) begin
            tick();
            if (new_note) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL basic_extra_note note=%0d dur=%0d", note, duration);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                        bad++;
                        $display("FAIL basic_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                    end
                end
                want_c = (nn == 0) ? 4 : nd_tick + 5;
                total++; if (c !== want_c) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", c, want_c); end
                nn++;
                nd_cnt = 3;
            end
            if (nn == 3 && c == nd_tick + 2) begin
                total++; if (rom_addr !== 7'h23) begin bad++; $display("FAIL basic_term_addr got=%h want=23", rom_addr); end
            end
            if (song_done) begin
                done = 1;
                play = 1'b0;
                total++; if (c !== nd_tick + 4) begin bad++; $display("FAIL basic_done_time got=%0d want=%0d", c, nd_tick + 4); end
                total++; if (nn !== 3) begin bad++; $display("FAIL basic_note_count got=%0d want=3", nn); end
            end
            note_done = 1'b0;
            if (nd_cnt > 0) begin
                nd_cnt--;
                if (nd_cnt == 0) begin note_done = 1'b1; nd_tick = c; end
            end
        end
        note_done = 1'b0;
        total++; if (done == 0) begin bad++; $display("FAIL basic_song_done_timeout got=none want=pulse"); end
        tick();
        total++; if (song_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", song_done); end
        total++; if (rom_addr !== 7'h20) begin bad++; $display("FAIL basic_index_cleared got=%h want=20", rom_addr); end
        total++; if ({note, duration} !== {6'd12, 6'd4}) begin bad++; $display("FAIL basic_held got=%0d/%0d want=12/4", note, duration); end
    endtask

    task automatic test_full_song();
        exp_t e;
        logic [6:0] max_addr;
        int nn, nd_tick, done, got;
        logic nn_prev;
        restart();
        for (int i = 0; i < 32; i++) begin
            rom[7'h40 + i] = {6'(i + 1), 6'(i + 2)};
            push_exp(7'(7'h40 + i));
        end
        song = 2'd2;
        play = 1'b1;
        nn = 0; nd_tick = -100; done = 0; nn_prev = 1'b0; max_addr = '0;
        for (int c = 1; c <= 400 && done == 0; c++) begin
            tick();
            if (rom_addr > max_addr) max_addr = rom_addr;
            if (new_note) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL full_extra_note note=%0d dur=%0d", note, duration);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                        bad++;
                        $display("FAIL full_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                    end
                end
                nn++;
            end
            if (song_done) begin
                done = 1;
                total++; if (c !== nd_tick + 2) begin bad++; $display("FAIL full_done_time got=%0d want=%0d", c, nd_tick + 2); end
            end
            note_done = nn_prev;
            if (nn_prev) nd_tick = c;
            nn_prev = new_note;
        end
        note_done = 1'b0;
        total++; if (done == 0) begin bad++; $display("FAIL full_song_done_timeout got=none want=pulse"); end
        total++; if (nn !== 32) begin bad++; $display("FAIL full_note_count got=%0d want=32", nn); end
        total++; if (max_addr > 7'h5F) begin bad++; $display("FAIL full_addr_range got=%h want<=5f", max_addr); end
        push_exp(7'h40);
        tick();
        tick();
        total++; if (rom_addr !== 7'h40) begin bad++; $display("FAIL full_refetch got=%h want=40", rom_addr); end
        got = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (new_note && got == 0) begin
                got = k;
                e = exp_q.pop_front();
                total++;
                if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                    bad++;
                    $display("FAIL full_restart_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                end
            end
        end
        total++; if (got !== 3) begin bad++; $display("FAIL full_restart_latency got=%0d want=3", got); end
        play = 1'b0;
    endtask

    task automatic test_pause();
        exp_t e;
        int hi, got;
        rom[7'h60] = {6'd7, 6'd5};
        for (int p = 1; p <= 3; p++) begin
            restart();
            song = 2'd3;
            push_exp(7'h60);
            play = 1'b1;
            repeat (p) tick();
            play = 1'b0;
            hi = 0;
            repeat (10) begin
                tick();
                if (new_note) hi++;
            end
            total++; if (hi !== 0) begin bad++; $display("FAIL pause_%0d_quiet got=%0d want=0", p, hi); end
            play = 1'b1;
            got = 0;
            for (int c = 1; c <= 8; c++) begin
                tick();
                if (new_note && got == 0) begin
                    got = c;
                    e = exp_q.pop_front();
                    total++;
                    if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                        bad++;
                        $display("FAIL pause_%0d_note got=%0d/%0d@%h want=%0d/%0d@%h", p, note, duration, rom_addr, e.n, e.d, e.a);
                    end
                end
            end
            total++; if (got !== 4 - p) begin bad++; $display("FAIL pause_%0d_resume got=%0d want=%0d", p, got, 4 - p); end
        end
        play = 1'b0;
    endtask

    task automatic test_reset_play();
        exp_t e;
        int nn, got, sd, hit;
        logic nn_prev;
        restart();
        for (int i = 0; i < 32; i++) rom[i] = {6'(i + 10), 6'(i + 2)};
        for (int i = 0; i < 8; i++) push_exp(7'(i));
        song = 2'd0;
        play = 1'b1;
        nn = 0; nn_prev = 1'b0; hit = 0;
        for (int c = 1; c <= 200 && hit == 0; c++) begin
            tick();
            if (new_note) begin
                e = exp_q.pop_front();
                total++;
                if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                    bad++;
                    $display("FAIL rp_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                end
                nn++;
                if (nn == 8) hit = 1;
            end
            if (hit == 0) begin
                note_done = nn_prev;
                nn_prev = new_note;
            end
        end
        total++; if (hit == 0) begin bad++; $display("FAIL rp_reach_index7_timeout got=%0d want=8", nn); end
        note_done  = 1'b0;
        reset_play = 1'b1;
        tick();
        reset_play = 1'b0;
        total++; if (rom_addr !== 7'h00) begin bad++; $display("FAIL rp_index_cleared got=%h want=00", rom_addr); end
        total++; if ({new_note, song_done} !== 2'b00) begin bad++; $display("FAIL rp_pulses got=%b%b want=00", new_note, song_done); end
        push_exp(7'h00);
        got = 0; sd = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (song_done) sd++;
            if (new_note && got == 0) begin
                got = c;
                e = exp_q.pop_front();
                total++;
                if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                    bad++;
                    $display("FAIL rp_restart_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                end
            end
        end
        total++; if (sd !== 0) begin bad++; $display("FAIL rp_no_song_done got=%0d want=0", sd); end
        total++; if (got !== 4) begin bad++; $display("FAIL rp_restart_latency got=%0d want=4", got); end
        play = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int nn;
        logic nn_prev;
        logic [4:0] addr_lo;
        restart();
        song = 2'd1;
        push_exp(7'h20); push_exp(7'h21);
        play = 1'b1;
        nn = 0; nn_prev = 1'b0;
        for (int c = 1; c <= 40 && nn < 2; c++) begin
            tick();
            if (new_note) begin
                e = exp_q.pop_front();
                total++;
                if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                    bad++;
                    $display("FAIL ar_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                end
                nn++;
            end
            if (nn < 2) begin
                note_done = nn_prev;
                nn_prev = new_note;
            end
        end
        note_done = 1'b0;
        total++; if (nn !== 2) begin bad++; $display("FAIL ar_reach_wait_timeout got=%0d want=2", nn); end
        #2;
        reset = 1'b1;
        #1;
        addr_lo = rom_addr[4:0];
        total++; if ({note, duration} !== 12'd0) begin bad++; $display("FAIL ar_note_dur got=%0d/%0d want=0/0", note, duration); end
        total++; if ({new_note, song_done} !== 2'b00) begin bad++; $display("FAIL ar_pulses got=%b%b want=00", new_note, song_done); end
        total++; if (addr_lo !== 5'd0) begin bad++; $display("FAIL ar_index got=%0d want=0", addr_lo); end
        tick();
        play  = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ignore_note_done();
        exp_t e;
        int errs, got;
        restart();
        song = 2'd3;
        rom[7'h60] = {6'd7, 6'd5};
        rom[7'h61] = {6'd8, 6'd6};
        push_exp(7'h60); push_exp(7'h61);
        note_done = 1'b1;
        errs = 0;
        repeat (3) begin
            tick();
            if (rom_addr !== 7'h60 || new_note !== 1'b0) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL ign_idle got=%0d want=0", errs); end
        play = 1'b1;
        repeat (3) tick();
        play = 1'b0;
        errs = 0;
        repeat (4) begin
            tick();
            if (rom_addr !== 7'h60 || new_note !== 1'b0) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL ign_issue got=%0d want=0", errs); end
        play = 1'b1;
        tick();
        total++; if (new_note !== 1'b1) begin bad++; $display("FAIL ign_issue_release got=%b want=1", new_note); end
        if (new_note) begin
            e = exp_q.pop_front();
            total++;
            if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                bad++;
                $display("FAIL ign_first_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
            end
        end
        tick();
        note_done = 1'b0;
        errs = 0;
        repeat (4) begin
            tick();
            if (rom_addr !== 7'h60 || new_note !== 1'b0) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL ign_same_cycle got=%0d want=0", errs); end
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        got = 0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (new_note && got == 0) begin
                got = c;
                e = exp_q.pop_front();
                total++;
                if ({note, duration, rom_addr} !== {e.n, e.d, e.a}) begin
                    bad++;
                    $display("FAIL ign_second_note got=%0d/%0d@%h want=%0d/%0d@%h", note, duration, rom_addr, e.n, e.d, e.a);
                end
            end
        end
        total++; if (got !== 5) begin bad++; $display("FAIL ign_advance_gap got=%0d want=5", got); end
        play = 1'b0;
    endtask

    task automatic test_pulse_width();
        total++;
        if (pulse_err !== 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", pulse_err); end
    endtask

    initial begin
        test_reset();
        test_basic_song();
        test_full_song();
        test_pause();
        test_reset_play();
        test_async_reset();
        test_ignore_note_done();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
